// File: rtl/ysyx_25040109_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040109_trap_ctrl
// Description : CSR / trap sequencer driving the single CSR write port and
//               the GPR write port of the register/CSR file.
//               - csrrw/csrrs/csrrc (+ immediate forms): one cycle, no stall.
//               - mret: one cycle, mstatus update and redirect to mepc.
//               - ecall/ebreak: four-cycle sequence writing mepc, mcause and
//                 mstatus on consecutive cycles, then redirecting to mtvec.
//                 Fetch is stalled for the three write cycles.
// Ports       :
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, is_*            decoded instruction valid and class flags
//   funct3, csr_addr_i       CSR operation and address from the instruction
//   rs1_idx, rs1_data, rd_i  source index/zimm, source value, destination
//   pc_i                     PC of the instruction
//   csr_rdata                combinational read of csr_addr
//   mepc_in, mtvec_in        current mepc / mtvec
//   csr_we/addr/wdata        CSR write port
//   gpr_wen/waddr/wdata      GPR write port (old CSR value -> rd)
//   stall                    hold PC and instruction this cycle
//   redirect_valid/pc        PC load request and target
//   busy                     trap sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040109_trap_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ECALL_CAUSE  = 11,
    parameter int EBREAK_CAUSE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  is_csr,
    input  logic                  is_ecall,
    input  logic                  is_ebreak,
    input  logic                  is_mret,
    input  logic [2:0]            funct3,
    input  logic [11:0]           csr_addr_i,
    input  logic [4:0]            rs1_idx,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [4:0]            rd_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    output logic                  csr_we,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  gpr_wen,
    output logic [4:0]            gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  busy
);

    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;

    // mstatus field positions
    localparam int c_MIE     = 3;
    localparam int c_MPIE    = 7;
    localparam int c_MPP_LO  = 11;
    localparam int c_MPP_HI  = 12;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_W_CAUSE  = 2'd1,
        S_W_STATUS = 2'd2,
        S_REDIR    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_cause;

    logic                  w_take_trap;
    logic [DATA_WIDTH-1:0] w_cause_sel;
    logic [1:0]            w_csr_op;
    logic [DATA_WIDTH-1:0] w_csr_src;
    logic [DATA_WIDTH-1:0] w_mret_status;
    logic [DATA_WIDTH-1:0] w_trap_status;

    logic                  w_we;
    logic [11:0]           w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_gwen;
    logic [4:0]            w_gwaddr;
    logic [DATA_WIDTH-1:0] w_gwdata;
    logic                  w_stall;
    logic                  w_redir;
    logic [DATA_WIDTH-1:0] w_rpc;

    // ------------------------------------------------------------------------
    // Instruction decode helpers
    // ------------------------------------------------------------------------
    // ecall wins over ebreak when both flags are set.
    assign w_take_trap = (r_state == S_IDLE) && valid_i && (is_ecall || is_ebreak);
    assign w_cause_sel = is_ecall ? DATA_WIDTH'(ECALL_CAUSE) : DATA_WIDTH'(EBREAK_CAUSE);

    // funct3[1:0]: 01 RW, 10 RS, 11 RC; funct3[2] selects zimm as the source.
    assign w_csr_op  = funct3[1:0];
    assign w_csr_src = funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx} : rs1_data;

    // mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
    always_comb begin
        w_mret_status                  = csr_rdata;
        w_mret_status[c_MIE]           = csr_rdata[c_MPIE];
        w_mret_status[c_MPIE]          = 1'b1;
        w_mret_status[c_MPP_HI:c_MPP_LO] = 2'b11;
    end

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    always_comb begin
        w_trap_status                  = csr_rdata;
        w_trap_status[c_MPIE]          = csr_rdata[c_MIE];
        w_trap_status[c_MIE]           = 1'b0;
        w_trap_status[c_MPP_HI:c_MPP_LO] = 2'b11;
    end

    // ------------------------------------------------------------------------
    // State and latched cause
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            if (w_take_trap) begin
                r_cause <= w_cause_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and raw outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_gwen   = 1'b0;
        w_gwaddr = '0;
        w_gwdata = '0;
        w_stall  = 1'b0;
        w_redir  = 1'b0;
        w_rpc    = '0;

        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    if (is_ecall || is_ebreak) begin
                        // First trap write happens in the accepting cycle.
                        w_addr  = c_CSR_MEPC;
                        w_wdata = pc_i;
                        w_we    = 1'b1;
                        w_stall = 1'b1;
                        w_next  = S_W_CAUSE;
                    end else if (is_mret) begin
                        w_addr  = c_CSR_MSTATUS;
                        w_wdata = w_mret_status;
                        w_we    = 1'b1;
                        w_redir = 1'b1;
                        w_rpc   = mepc_in;
                    end else if (is_csr && (w_csr_op != 2'b00)) begin
                        w_addr = csr_addr_i;
                        case (w_csr_op)
                            2'b01:   w_wdata = w_csr_src;
                            2'b10:   w_wdata = csr_rdata | w_csr_src;
                            default: w_wdata = csr_rdata & ~w_csr_src;
                        endcase
                        // Set/clear with rs1/zimm == 0 must not write the CSR.
                        w_we     = (w_csr_op == 2'b01) || (rs1_idx != 5'd0);
                        w_gwen   = (rd_i != 5'd0);
                        w_gwaddr = rd_i;
                        w_gwdata = csr_rdata;
                    end
                end
            end
            S_W_CAUSE: begin
                w_addr  = c_CSR_MCAUSE;
                w_wdata = r_cause;
                w_we    = 1'b1;
                w_stall = 1'b1;
                w_next  = S_W_STATUS;
            end
            S_W_STATUS: begin
                w_addr  = c_CSR_MSTATUS;
                w_wdata = w_trap_status;
                w_we    = 1'b1;
                w_stall = 1'b1;
                w_next  = S_REDIR;
            end
            S_REDIR: begin
                w_redir = 1'b1;
                w_rpc   = {mtvec_in[DATA_WIDTH-1:2], 2'b00};
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are forced quiet during the reset cycle so an in-flight trap
    // cannot issue a write or a redirect while being aborted.
    // ------------------------------------------------------------------------
    assign csr_we         = w_we & ~rst;
    assign csr_addr       = rst ? '0 : w_addr;
    assign csr_wdata      = rst ? '0 : w_wdata;
    assign gpr_wen        = w_gwen & ~rst;
    assign gpr_waddr      = rst ? '0 : w_gwaddr;
    assign gpr_wdata      = rst ? '0 : w_gwdata;
    assign stall          = w_stall & ~rst;
    assign redirect_valid = w_redir & ~rst;
    assign redirect_pc    = rst ? '0 : w_rpc;
    assign busy           = (r_state != S_IDLE) & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040109_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040109_trap_ctrl
// Description : Self-checking bench for ysyx_25040109_trap_ctrl. The bench
//               acts as the CSR file (env_csr, written by the DUT) and keeps
//               an independent expected CSR image (ref_csr) updated from the
//               architectural rules of each instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040109_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, is_csr, is_ecall, is_ebreak, is_mret;
    logic [2:0]  funct3;
    logic [11:0] csr_addr_i;
    logic [4:0]  rs1_idx, rd_i;
    logic [31:0] rs1_data, pc_i, csr_rdata, mepc_in, mtvec_in;
    logic        csr_we, gpr_wen, stall, redirect_valid, busy;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, gpr_wdata, redirect_pc;
    logic [4:0]  gpr_waddr;

    logic [31:0] env_csr [0:4095];
    logic [31:0] ref_csr [0:4095];
    logic        tb_we = 1'b0;
    logic [11:0] tb_waddr = '0;
    logic [31:0] tb_wdata = '0;

    int checks   = 0;
    int failures = 0;

    logic [11:0] addr_set [0:7];

    ysyx_25040109_trap_ctrl #(
        .DATA_WIDTH  (32),
        .ECALL_CAUSE (11),
        .EBREAK_CAUSE(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .is_csr        (is_csr),
        .is_ecall      (is_ecall),
        .is_ebreak     (is_ebreak),
        .is_mret       (is_mret),
        .funct3        (funct3),
        .csr_addr_i    (csr_addr_i),
        .rs1_idx       (rs1_idx),
        .rs1_data      (rs1_data),
        .rd_i          (rd_i),
        .pc_i          (pc_i),
        .csr_rdata     (csr_rdata),
        .mepc_in       (mepc_in),
        .mtvec_in      (mtvec_in),
        .csr_we        (csr_we),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .gpr_wen       (gpr_wen),
        .gpr_waddr     (gpr_waddr),
        .gpr_wdata     (gpr_wdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Environment CSR file: bench preload has priority, otherwise DUT writes.
    always @(posedge clk) begin
        if (tb_we)       env_csr[tb_waddr] <= tb_wdata;
        else if (csr_we) env_csr[csr_addr] <= csr_wdata;
    end
    assign csr_rdata = env_csr[csr_addr];
    assign mepc_in   = env_csr[12'h341];
    assign mtvec_in  = env_csr[12'h305];

    task automatic clear_inputs();
        valid_i = 0; is_csr = 0; is_ecall = 0; is_ebreak = 0; is_mret = 0;
        funct3 = 3'b000; csr_addr_i = '0; rs1_idx = '0; rs1_data = '0;
        rd_i = '0; pc_i = '0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
        @(posedge clk);
        @(negedge clk);
        tb_we = 1'b0;
        ref_csr[a] = v;
    endtask

    // One CSR instruction; expected values from the Zicsr rules.
    task automatic do_csr(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] r1, input logic [31:0] r1d,
                          input logic [4:0] rd);
        logic [31:0] old, src, nv;
        logic        ewe, egw;
        old = ref_csr[a];
        src = f3[2] ? {27'b0, r1} : r1d;
        if (f3[1:0] == 2'b01)      nv = src;
        else if (f3[1:0] == 2'b10) nv = old | src;
        else                       nv = old & ~src;
        ewe = (f3[1:0] == 2'b01) || (r1 != 5'd0);
        egw = (rd != 5'd0);
        clear_inputs();
        valid_i = 1; is_csr = 1; funct3 = f3; csr_addr_i = a;
        rs1_idx = r1; rs1_data = r1d; rd_i = rd;
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== {ewe, egw, 3'b000}) begin
            failures++;
            $display("FAIL csr_ctrl f3=%b got we/gw/st/rv/busy=%b%b%b%b%b exp=%b%b000",
                     f3, csr_we, gpr_wen, stall, redirect_valid, busy, ewe, egw);
        end
        checks++;
        if (csr_addr !== a) begin
            failures++;
            $display("FAIL csr_addr got=%h exp=%h", csr_addr, a);
        end
        if (ewe) begin
            checks++;
            if (csr_wdata !== nv) begin
                failures++;
                $display("FAIL csr_wdata f3=%b got=%h exp=%h", f3, csr_wdata, nv);
            end
        end
        if (egw) begin
            checks++;
            if ({gpr_waddr, gpr_wdata} !== {rd, old}) begin
                failures++;
                $display("FAIL gpr_write got x%0d=%h exp x%0d=%h", gpr_waddr, gpr_wdata, rd, old);
            end
        end
        @(posedge clk);
        if (ewe) ref_csr[a] = nv;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (env_csr[a] !== ref_csr[a]) begin
            failures++;
            $display("FAIL csr_state addr=%h got=%h exp=%h", a, env_csr[a], ref_csr[a]);
        end
    endtask

    task automatic do_mret();
        logic [31:0] ms, nv, epc;
        ms  = ref_csr[12'h300];
        epc = ref_csr[12'h341];
        nv  = (ms & ~32'h0000_1888) | (((ms >> 7) & 32'd1) << 3) | 32'h0000_1880;
        clear_inputs();
        valid_i = 1; is_mret = 1; rd_i = 5'd9;
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b10010) begin
            failures++;
            $display("FAIL mret_ctrl got=%b%b%b%b%b exp=10010",
                     csr_we, gpr_wen, stall, redirect_valid, busy);
        end
        checks++;
        if ({csr_addr, csr_wdata, redirect_pc} !== {12'h300, nv, epc}) begin
            failures++;
            $display("FAIL mret_data got addr=%h wd=%h rpc=%h exp addr=300 wd=%h rpc=%h",
                     csr_addr, csr_wdata, redirect_pc, nv, epc);
        end
        @(posedge clk);
        ref_csr[12'h300] = nv;
        @(negedge clk);
        clear_inputs();
    endtask

    // Full ecall/ebreak sequence. extra: also raise lower-priority flags at
    // acceptance and scramble inputs during W_CAUSE. rmid: reset in W_STATUS.
    task automatic do_trap(input bit eb, input logic [31:0] pc,
                           input bit extra, input bit rmid);
        logic [31:0] cause, ms, nv;
        cause = eb ? 32'd3 : 32'd11;
        clear_inputs();
        valid_i = 1; is_ecall = !eb; is_ebreak = eb; pc_i = pc; rd_i = 5'd3;
        if (extra) begin
            is_mret = 1; is_csr = 1; funct3 = 3'b001; csr_addr_i = 12'h305;
            rs1_idx = 5'd1; rs1_data = 32'hDEAD_BEEF;
        end
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b10100
            || csr_addr !== 12'h341 || csr_wdata !== pc) begin
            failures++;
            $display("FAIL trap_mepc ctrl=%b%b%b%b%b addr=%h wd=%h exp ctrl=10100 addr=341 wd=%h",
                     csr_we, gpr_wen, stall, redirect_valid, busy, csr_addr, csr_wdata, pc);
        end
        @(posedge clk);
        ref_csr[12'h341] = pc;
        @(negedge clk);
        if (extra) begin
            valid_i = 1; is_ecall = 1'($urandom); is_ebreak = 1'($urandom);
            is_mret = 1; is_csr = 1; funct3 = 3'($urandom); pc_i = $urandom;
            csr_addr_i = 12'h300; rs1_idx = 5'($urandom); rs1_data = $urandom;
        end
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b10101
            || csr_addr !== 12'h342 || csr_wdata !== cause) begin
            failures++;
            $display("FAIL trap_mcause ctrl=%b%b%b%b%b addr=%h wd=%h exp ctrl=10101 addr=342 wd=%h",
                     csr_we, gpr_wen, stall, redirect_valid, busy, csr_addr, csr_wdata, cause);
        end
        @(posedge clk);
        ref_csr[12'h342] = cause;
        @(negedge clk);
        if (rmid) begin
            rst = 1;
            #1;
            checks++;
            if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b00000) begin
                failures++;
                $display("FAIL rst_cycle ctrl=%b%b%b%b%b exp=00000",
                         csr_we, gpr_wen, stall, redirect_valid, busy);
            end
            @(posedge clk);
            @(negedge clk);
            rst = 0;
            clear_inputs();
            for (int k = 0; k < 2; k++) begin
                #1;
                checks++;
                if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b00000) begin
                    failures++;
                    $display("FAIL post_rst cyc=%0d ctrl=%b%b%b%b%b exp=00000",
                             k, csr_we, gpr_wen, stall, redirect_valid, busy);
                end
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if ({env_csr[12'h341], env_csr[12'h342], env_csr[12'h300]} !==
                {ref_csr[12'h341], ref_csr[12'h342], ref_csr[12'h300]}) begin
                failures++;
                $display("FAIL rst_keep mepc=%h mcause=%h mstatus=%h exp %h %h %h",
                         env_csr[12'h341], env_csr[12'h342], env_csr[12'h300],
                         ref_csr[12'h341], ref_csr[12'h342], ref_csr[12'h300]);
            end
            return;
        end
        ms = ref_csr[12'h300];
        nv = (ms & ~32'h0000_1888) | (((ms >> 3) & 32'd1) << 7) | 32'h0000_1800;
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b10101
            || csr_addr !== 12'h300 || csr_wdata !== nv) begin
            failures++;
            $display("FAIL trap_mstatus ctrl=%b%b%b%b%b addr=%h wd=%h exp ctrl=10101 addr=300 wd=%h",
                     csr_we, gpr_wen, stall, redirect_valid, busy, csr_addr, csr_wdata, nv);
        end
        @(posedge clk);
        ref_csr[12'h300] = nv;
        @(negedge clk);
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy} !== 5'b00011
            || redirect_pc !== (ref_csr[12'h305] & ~32'd3)) begin
            failures++;
            $display("FAIL trap_redir ctrl=%b%b%b%b%b rpc=%h exp ctrl=00011 rpc=%h",
                     csr_we, gpr_wen, stall, redirect_valid, busy, redirect_pc,
                     ref_csr[12'h305] & ~32'd3);
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({env_csr[12'h341], env_csr[12'h342], env_csr[12'h300]} !==
            {ref_csr[12'h341], ref_csr[12'h342], ref_csr[12'h300]}) begin
            failures++;
            $display("FAIL trap_state mepc=%h mcause=%h mstatus=%h exp %h %h %h",
                     env_csr[12'h341], env_csr[12'h342], env_csr[12'h300],
                     ref_csr[12'h341], ref_csr[12'h342], ref_csr[12'h300]);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        valid_i = 1; is_ecall = 1; is_csr = 1; funct3 = 3'b001;
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy, csr_addr, csr_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ctrl=%b%b%b%b%b addr=%h wd=%h exp all zero",
                     csr_we, gpr_wen, stall, redirect_valid, busy, csr_addr, csr_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        clear_inputs();
        #1;
        checks++;
        if ({csr_we, gpr_wen, stall, redirect_valid, busy, redirect_pc} !== '0) begin
            failures++;
            $display("FAIL idle_outputs ctrl=%b%b%b%b%b rpc=%h exp all zero",
                     csr_we, gpr_wen, stall, redirect_valid, busy, redirect_pc);
        end
    endtask

    task automatic test_directed();
        preload(12'h305, 32'h0);
        do_csr(3'b001, 12'h305, 5'd6, 32'h8000_0100, 5'd5);
        preload(12'h300, 32'h0000_1888);
        do_csr(3'b010, 12'h300, 5'd0, 32'h0, 5'd0);
        do_csr(3'b111, 12'h300, 5'd8, 32'h0, 5'd7);
        preload(12'h300, 32'h0000_1808);
        preload(12'h305, 32'h8000_0203);
        do_trap(1'b0, 32'h8000_0040, 1'b0, 1'b0);
        preload(12'h341, 32'h8000_0044);
        do_mret();
    endtask

    task automatic test_csr_random();
        for (int i = 0; i < 40; i++) begin
            int pick;
            logic [2:0] f3;
            logic [4:0] r1;
            pick = int'($urandom_range(0, 5));
            f3   = (pick < 3) ? 3'(pick + 1) : 3'(pick + 2);
            r1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_csr(f3, addr_set[$urandom_range(0, 7)], r1, $urandom, 5'($urandom));
        end
    endtask

    task automatic test_priority();
        do_trap(1'b0, 32'h8000_1000, 1'b1, 1'b0);
        do_trap(1'b1, 32'h8000_2004, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_trap();
        do_trap(1'b1, 32'h8000_3008, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0)      do_mret();
            else if (kind == 1) do_trap(1'($urandom), {$urandom} & ~32'd3, 1'($urandom), 1'b0);
            else                do_csr(3'b001 + 3'($urandom_range(0, 2)), addr_set[$urandom_range(0, 7)],
                                       5'($urandom), $urandom, 5'($urandom));
        end
    endtask

    initial begin
        addr_set[0] = 12'h300; addr_set[1] = 12'h305; addr_set[2] = 12'h341;
        addr_set[3] = 12'h342; addr_set[4] = 12'h340; addr_set[5] = 12'h344;
        addr_set[6] = 12'h7C0; addr_set[7] = 12'h001;
        rst = 1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        for (int i = 0; i < 8; i++) preload(addr_set[i], $urandom);
        test_directed();
        test_csr_random();
        test_priority();
        test_reset_mid_trap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
